exe_stage_unit: RTL
===================

# exe_stage_unit

Execute stage of the 5-stage ARM pipeline. Consumes the decoded fields held in the ID/EX pipeline register and produces the ALU result, the branch target and the branch-taken flush pulse for IF/ID. Owns the NZCV status register that feeds `sr` back to the ID stage. Registers its results into the EX/MEM boundary, with freeze support for memory stalls.

## Interface
Parameters:
- none. All widths are fixed by the ARM datapath.

Ports (clock and reset first):
- `clk` input 1: pipeline clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `freeze` input 1: holds the EX/MEM outputs and the status register.
- `wb_en_in, mem_r_en_in, mem_w_en_in` input 1 each: control from the ID/EX register.
- `b_in, s_in, imm_in` input 1 each: branch, set-flags and immediate flags.
- `exe_cmd_in` input 4: ALU command.
- `dest_in` input 4: destination register.
- `sr_in` input 4: NZCV captured at decode.
- `shift_operand_in` input 12: operand-2 field.
- `imm_signed_24_in` input 24: branch offset.
- `PC_in, value_rn_in, value_rm_in` input 32: PC+4 of the instruction, and the Rn/Rm values.
- `fwd_sel_1, fwd_sel_2` input 2: forwarding select. 0 = register value, 1 = `mem_fwd_val`, 2 = `wb_fwd_val`; 3 is treated as 0.
- `mem_fwd_val, wb_fwd_val` input 32: forwarded results from later stages.
- `branch_taken` output 1: combinational, equals `b_in`; flushes IF/ID and the ID/EX register.
- `branch_addr` output 32: combinational branch target.
- `sr` output 4: registered NZCV.
- `wb_en, mem_r_en, mem_w_en` output 1 each: registered control to MEM.
- `alu_res` output 32: registered ALU result or memory address.
- `st_val` output 32: registered store data, taken from forwarded Rm.
- `dest` output 4: registered destination register.

## Operation
- Operand A is `value_rn_in` after forwarding mux 1. Rm is `value_rm_in` after forwarding mux 2.
- Val2 generation:
  - `imm_in`=1: the 32-bit value {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Otherwise, if `mem_r_en_in` or `mem_w_en_in` is set: zero-extended so[11:0].
  - Otherwise: Rm shifted by so[11:7] using type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm unchanged.
- `exe_cmd` encodings:
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD = A+Val2; 0011 ADC = A+Val2+C.
  - 0100 SUB = A−Val2; 0101 SBC = A−Val2−!C.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - Any other code gives a result of 0.
  - The carry-in C is `sr_in[1]`.
- Flag rules:
  - N = res[31]; Z = (res==0).
  - Add: C = bit 32 of the 33-bit sum. V = operands have the same sign and the result sign differs.
  - Subtract: C = no borrow. V = operands have different signs and the result sign differs from A.
  - Logic and move: C and V are kept from `sr_in`.
- `branch_addr` = `PC_in` + (sign-extended `imm_signed_24_in` << 2), with 32-bit wrap-around.
- Status register: on a clock edge with `s_in`=1 and `freeze`=0, load {N,Z,C,V}.
- EX/MEM register: on a clock edge with `freeze`=0, load all registered outputs. With `freeze`=1, hold them.

## Timing
- Reset (`rst_n`=0, asynchronous): `sr`, `wb_en`, `mem_r_en`, `mem_w_en`, `alu_res`, `st_val` and `dest` all go to 0 immediately and stay at 0 until the first rising edge after deassertion.
- `branch_taken` and `branch_addr` have zero latency and are combinational from the inputs.
- ALU result: 1-cycle latency to `alu_res`. Flags: 1-cycle latency to `sr`.
- Freeze and an instruction with `s_in`=1 in the same cycle: `sr` holds its value; the instruction is re-presented upstream.
- Branch with `s_in`=0: `sr` is unchanged. The EX/MEM controls latch the branch's zero control bits, which ID already provides.
- Reset asserted mid-stream discards the in-flight result. No partial update is allowed.

## Structure
- Shared package `arm_pkg`: the `exe_cmd` localparams (MOV…EOR), the shift-type codes, the forwarding-select codes, and the NZCV bit indices.
- One sub-module, `val2_generator`, which is combinational: Val2 from `imm_in`, the memory flag, `shift_operand_in` and Rm.
- The ALU, flag logic, status register and EX/MEM register live in the top module.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle. All registered outputs must read 0 immediately; `sr`=0000.
- ADDS with Rn=0x7FFFFFFF, Val2 = imm 1 (so=0x001), s=1 → next edge: `alu_res`=0x80000000, `sr`=1001 (N, V).
- SUBS with Rn=5, Rm=5, shift LSL 0, s=1 → `alu_res`=0, `sr`=0110 (Z, C).
- Rotated immediate: so=0x4FF, MOV → `alu_res`=0xFF000000. Then ROR Rm=0x1, so=0x060 (ROR #0) and so=0x0E0 (ROR #1) → 0x1 and 0x80000000.
- Branch: `PC_in`=0x100, `imm_signed_24_in`=0xFFFFFE, `b_in`=1 → same cycle `branch_taken`=1 and `branch_addr`=0xF8.
- Forwarding and freeze: `fwd_sel_1`=1, `mem_fwd_val`=10, ADD with imm 3 → `alu_res`=13. Then `freeze`=1 for 2 cycles with new inputs → `alu_res` stays 13 and `sr` is unchanged.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: ALU command codes, shift types,
// forwarding selects and NZCV bit positions.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/exe_stage_unit_if.sv
// Bundle of the ID/EX inputs, forwarding values and EX/MEM outputs of the
// execute stage; slave is the stage itself, master is whoever drives it.
interface exe_stage_unit_if;
    logic        freeze;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic        b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in;
    logic [3:0]  dest_in;
    logic [3:0]  sr_in;
    logic [11:0] shift_operand_in;
    logic [23:0] imm_signed_24_in;
    logic [31:0] PC_in, value_rn_in, value_rm_in;
    logic [1:0]  fwd_sel_1, fwd_sel_2;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  sr;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;

    modport master (
        output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
               exe_cmd_in, dest_in, sr_in, shift_operand_in, imm_signed_24_in,
               PC_in, value_rn_in, value_rm_in, fwd_sel_1, fwd_sel_2,
               mem_fwd_val, wb_fwd_val,
        input  branch_taken, branch_addr, sr, wb_en, mem_r_en, mem_w_en,
               alu_res, st_val, dest
    );

    modport slave (
        input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
               exe_cmd_in, dest_in, sr_in, shift_operand_in, imm_signed_24_in,
               PC_in, value_rn_in, value_rm_in, fwd_sel_1, fwd_sel_2,
               mem_fwd_val, wb_fwd_val,
        output branch_taken, branch_addr, sr, wb_en, mem_r_en, mem_w_en,
               alu_res, st_val, dest
    );
endinterface

// File: rtl/val2_generator.sv
// Combinational operand-2 builder: rotated immediate, zero-extended memory
// offset, or shifted Rm.
module val2_generator
    import arm_pkg::*;
(
    input  logic        imm,
    input  logic        mem_en,
    input  logic [11:0] shift_operand,
    input  logic [31:0] rm,
    output logic [31:0] val2
);

    logic [4:0] shift_amt_s;
    assign shift_amt_s = shift_operand[11:7];

    // Select the operand-2 form; a zero shift amount leaves Rm untouched for every type.
    always_comb begin
        val2 = 32'd0;
        if (imm) begin
            val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
        end else if (mem_en) begin
            val2 = {20'd0, shift_operand};
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = rm << shift_amt_s;
                SH_LSR:  val2 = rm >> shift_amt_s;
                SH_ASR:  val2 = $unsigned($signed(rm) >>> shift_amt_s);
                SH_ROR:  val2 = ror32(rm, shift_amt_s);
                default: val2 = rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_unit.sv
// ARM execute stage: forwarding, ALU with NZCV generation, branch target,
// status register and the freezable EX/MEM pipeline register.
module exe_stage_unit
    import arm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    exe_stage_unit_if.slave  bus
);

    logic [31:0] op_a_s, rm_fwd_s, val2_s, res_s;
    logic [32:0] sum_s;
    logic        carry_s, ovf_s;
    logic [3:0]  nzcv_s;

    logic [3:0]  sr_r;
    logic        wb_en_r, mem_r_en_r, mem_w_en_r;
    logic [31:0] alu_res_r, st_val_r;
    logic [3:0]  dest_r;

    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
        case (sel)
            FWD_MEM: return mem_val;
            FWD_WB:  return wb_val;
            default: return reg_val;
        endcase
    endfunction

    assign op_a_s   = fwd_mux(bus.fwd_sel_1, bus.value_rn_in, bus.mem_fwd_val, bus.wb_fwd_val);
    assign rm_fwd_s = fwd_mux(bus.fwd_sel_2, bus.value_rm_in, bus.mem_fwd_val, bus.wb_fwd_val);

    val2_generator u_val2 (
        .imm           (bus.imm_in),
        .mem_en        (bus.mem_r_en_in | bus.mem_w_en_in),
        .shift_operand (bus.shift_operand_in),
        .rm            (rm_fwd_s),
        .val2          (val2_s)
    );

    // ALU; subtraction is A + ~B + carry-in so bit 32 is directly the no-borrow flag.
    always_comb begin
        sum_s   = 33'd0;
        res_s   = 32'd0;
        carry_s = bus.sr_in[SR_C];
        ovf_s   = bus.sr_in[SR_V];
        case (bus.exe_cmd_in)
            EXE_MOV: res_s = val2_s;
            EXE_MVN: res_s = ~val2_s;
            EXE_ADD, EXE_ADC: begin
                sum_s   = {1'b0, op_a_s} + {1'b0, val2_s}
                        + {32'd0, (bus.exe_cmd_in == EXE_ADC) & bus.sr_in[SR_C]};
                res_s   = sum_s[31:0];
                carry_s = sum_s[32];
                ovf_s   = (op_a_s[31] == val2_s[31]) && (sum_s[31] != op_a_s[31]);
            end
            EXE_SUB, EXE_SBC: begin
                sum_s   = {1'b0, op_a_s} + {1'b0, ~val2_s}
                        + {32'd0, (bus.exe_cmd_in == EXE_SUB) | bus.sr_in[SR_C]};
                res_s   = sum_s[31:0];
                carry_s = sum_s[32];
                ovf_s   = (op_a_s[31] != val2_s[31]) && (sum_s[31] != op_a_s[31]);
            end
            EXE_AND: res_s = op_a_s & val2_s;
            EXE_ORR: res_s = op_a_s | val2_s;
            EXE_EOR: res_s = op_a_s ^ val2_s;
            default: res_s = 32'd0;
        endcase
    end

    assign nzcv_s = {res_s[31], (res_s == 32'd0), carry_s, ovf_s};

    assign bus.branch_taken = bus.b_in;
    assign bus.branch_addr  = bus.PC_in + {{6{bus.imm_signed_24_in[23]}}, bus.imm_signed_24_in, 2'b00};

    // Status register: flag-setting instructions update it unless the pipe is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r <= 4'd0;
        end else if (bus.s_in && !bus.freeze) begin
            sr_r <= nzcv_s;
        end else begin
            sr_r <= sr_r;
        end
    end

    // EX/MEM pipeline register, held during memory stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_r    <= 1'b0;
            mem_r_en_r <= 1'b0;
            mem_w_en_r <= 1'b0;
            alu_res_r  <= 32'd0;
            st_val_r   <= 32'd0;
            dest_r     <= 4'd0;
        end else if (!bus.freeze) begin
            wb_en_r    <= bus.wb_en_in;
            mem_r_en_r <= bus.mem_r_en_in;
            mem_w_en_r <= bus.mem_w_en_in;
            alu_res_r  <= res_s;
            st_val_r   <= rm_fwd_s;
            dest_r     <= bus.dest_in;
        end else begin
            wb_en_r    <= wb_en_r;
            mem_r_en_r <= mem_r_en_r;
            mem_w_en_r <= mem_w_en_r;
            alu_res_r  <= alu_res_r;
            st_val_r   <= st_val_r;
            dest_r     <= dest_r;
        end
    end

    assign bus.sr       = sr_r;
    assign bus.wb_en    = wb_en_r;
    assign bus.mem_r_en = mem_r_en_r;
    assign bus.mem_w_en = mem_w_en_r;
    assign bus.alu_res  = alu_res_r;
    assign bus.st_val   = st_val_r;
    assign bus.dest     = dest_r;

endmodule
